// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the ctrl_sequencer fetch/decode/execute controller.
//   - field widths, opcode values, FSM state encoding
//   - accumulator mux select codes, ALU opcode codes
//   - ctl_t: decoded control word produced by instr_decode
package ctrl_pkg;

   localparam int PC_W  = 4;
   localparam int IMM_W = 4;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDI  = 4'h1;
   localparam logic [3:0] OP_LDR  = 4'h2;
   localparam logic [3:0] OP_STR  = 4'h3;
   localparam logic [3:0] OP_ADD  = 4'h4;
   localparam logic [3:0] OP_SUB  = 4'h5;
   localparam logic [3:0] OP_AND  = 4'h6;
   localparam logic [3:0] OP_OR   = 4'h7;
   localparam logic [3:0] OP_XOR  = 4'h8;
   localparam logic [3:0] OP_JMP  = 4'h9;
   localparam logic [3:0] OP_JZ   = 4'hA;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_HALT   = 3'd4
   } state_t;

   localparam logic [1:0] SEL_IMM = 2'b00;
   localparam logic [1:0] SEL_REG = 2'b01;
   localparam logic [1:0] SEL_ALU = 2'b10;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_XOR = 3'd4;

   typedef struct packed {
      logic [1:0] sel;
      logic [2:0] alu_op;
      logic       ld;
      logic       we;
      logic       jmp;
      logic       jz;
      logic       halt;
      logic       illegal;
   } ctl_t;

endpackage

// File: rtl/ctrl_sequencer_if.sv
// ctrl_sequencer_if: instruction-ROM and datapath-control bundle of the sequencer.
//   master (sequencer): in  run, instr_in, acc_zero
//                       out pc_out, rom_rd_en, load_acc, SelAcc, immediate,
//                           reg_addr, reg_we, alu_op, halted, illegal_op
//   slave  (ROM / accumulator stage / bench): mirror image of master
interface ctrl_sequencer_if #(
   parameter int PC_W  = 4,
   parameter int IMM_W = 4
);
   logic             run;
   logic [PC_W-1:0]  pc_out;
   logic             rom_rd_en;
   logic [7:0]       instr_in;
   logic             acc_zero;
   logic             load_acc;
   logic [1:0]       SelAcc;
   logic [IMM_W-1:0] immediate;
   logic [IMM_W-1:0] reg_addr;
   logic             reg_we;
   logic [2:0]       alu_op;
   logic             halted;
   logic             illegal_op;

   modport master (
      input  run, instr_in, acc_zero,
      output pc_out, rom_rd_en, load_acc, SelAcc, immediate,
             reg_addr, reg_we, alu_op, halted, illegal_op
   );

   modport slave (
      output run, instr_in, acc_zero,
      input  pc_out, rom_rd_en, load_acc, SelAcc, immediate,
             reg_addr, reg_we, alu_op, halted, illegal_op
   );
endinterface

// File: rtl/instr_decode.sv
// instr_decode: combinational opcode -> control word.
//   i_opcode  in  4      instruction opcode field (instr[7:4])
//   o_ctl     out ctl_t  {sel, alu_op, ld, we, jmp, jz, halt, illegal}
// Unused fields stay zero, so a NOP/jump leaves the mux on SEL_IMM and the ALU on ADD.
module instr_decode
   import ctrl_pkg::*;
(
   input  logic [3:0] i_opcode,
   output ctl_t       o_ctl
);

   always_comb begin
      o_ctl     = '0;
      o_ctl.sel = SEL_IMM;
      case (i_opcode)
         OP_NOP:  ;
         OP_LDI:  o_ctl.ld = 1'b1;
         OP_LDR: begin
            o_ctl.sel = SEL_REG;
            o_ctl.ld  = 1'b1;
         end
         OP_STR:  o_ctl.we = 1'b1;
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            o_ctl.sel    = SEL_ALU;
            // ALU opcodes are laid out in the same order as the arithmetic opcodes
            o_ctl.alu_op = 3'(i_opcode - OP_ADD);
            o_ctl.ld     = 1'b1;
         end
         OP_JMP:  o_ctl.jmp  = 1'b1;
         OP_JZ:   o_ctl.jz   = 1'b1;
         OP_HALT: o_ctl.halt = 1'b1;
         default: o_ctl.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: fetch/decode/execute controller feeding the accumulator/mux stage.
//   clk  in  1   system clock, all state on rising edge
//   clb  in  1   synchronous active-high reset
//   bus  ctrl_sequencer_if.master  ROM fetch port and datapath controls
// Every instruction takes FETCH, DECODE, EXECUTE (3 cycles). The IR is loaded at the
// end of DECODE; mux select, immediate, register address and ALU opcode are decoded
// from the IR, so they are stable for the whole EXECUTE cycle and beyond.
module ctrl_sequencer
   import ctrl_pkg::*;
#(
   parameter int PC_W  = 4,
   parameter int IMM_W = 4
) (
   input  logic                   clk,
   input  logic                   clb,
   ctrl_sequencer_if.master       bus
);

   state_t          r_state;
   state_t          w_state_next;
   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] w_pc_next;
   logic [PC_W-1:0] w_target;
   logic [7:0]      r_ir;
   ctl_t            w_ctl;
   logic            w_exec;

   instr_decode u_decode (
      .i_opcode (r_ir[7:4]),
      .o_ctl    (w_ctl)
   );

   assign w_target = PC_W'(r_ir[3:0]);

   always_ff @(posedge clk) begin
      if (clb) begin
         r_state <= ST_IDLE;
         r_pc    <= '0;
         r_ir    <= '0;
      end else begin
         r_state <= w_state_next;
         r_pc    <= w_pc_next;
         if (r_state == ST_DECODE) begin
            r_ir <= bus.instr_in;
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      case (r_state)
         ST_IDLE: begin
            if (bus.run) w_state_next = ST_FETCH;
         end
         ST_FETCH:  w_state_next = ST_DECODE;
         ST_DECODE: w_state_next = ST_EXEC;
         ST_EXEC: begin
            if (w_ctl.halt) begin
               w_state_next = ST_HALT;
            end else begin
               if (w_ctl.jmp || (w_ctl.jz && bus.acc_zero)) begin
                  w_pc_next = w_target;
               end else begin
                  w_pc_next = r_pc + PC_W'(1);
               end
               // run is only looked at on the instruction boundary
               w_state_next = bus.run ? ST_FETCH : ST_IDLE;
            end
         end
         ST_HALT:   w_state_next = ST_HALT;
         default:   w_state_next = ST_IDLE;
      endcase
   end

   // Strobes are masked by clb so a reset landing in EXECUTE never lets a load/write escape.
   assign w_exec = (r_state == ST_EXEC) && !clb;

   assign bus.pc_out     = r_pc;
   assign bus.rom_rd_en  = (r_state == ST_FETCH);
   assign bus.load_acc   = w_exec && w_ctl.ld;
   assign bus.reg_we     = w_exec && w_ctl.we;
   assign bus.illegal_op = w_exec && w_ctl.illegal;
   assign bus.SelAcc     = w_ctl.sel;
   assign bus.alu_op     = w_ctl.alu_op;
   assign bus.immediate  = IMM_W'(r_ir[3:0]);
   assign bus.reg_addr   = IMM_W'(r_ir[3:0]);
   assign bus.halted     = (r_state == ST_HALT);

endmodule
